byte_serial_addsub: RTL

Multi-cycle 16-bit add/subtract engine built on a single 8-bit slice adder. It runs two passes, low byte first and then high byte. It is the producer side of the calculator's low/high carry handshake: it drives islow and sign, emits the low-pass carry, and consumes it in the high pass. It sits between operand entry and the result display, and produces the final 16-bit result plus the carry/borrow LED.

---
 rtl/byte_serial_addsub.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/byte_serial_addsub.sv
// 16-bit add/sub on one 8-bit slice: low pass, then high pass. Done 3 edges after start; throughput 1 op / 4 cycles.
// No backpressure: start is sampled only in IDLE and ignored while busy; results hold until the next accepted start.
module byte_serial_addsub #(
  parameter int unsigned SLICE_W = 8,
  parameter logic [2:0]  OP_ADD  = 3'b011,
  parameter logic [2:0]  OP_SUB  = 3'b100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           sign,
  input  logic [2*SLICE_W-1:0] a,
  input  logic [2*SLICE_W-1:0] b,
  output logic                 busy,
  output logic                 islow,
  output logic [2:0]           sign_out,
  output logic                 carry_out,
  output logic [2*SLICE_W-1:0] result,
  output logic                 carry,
  output logic                 led2,
  output logic                 err,
  output logic                 done
);

  localparam int unsigned W = 2 * SLICE_W;

  typedef enum logic [1:0] {ST_IDLE, ST_LOW, ST_HIGH, ST_DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [2:0]     sign_q, sign_d;
  logic           carry_out_q, carry_out_d;
  logic [W-1:0]   result_q, result_d;
  logic           carry_q, carry_d;
  logic           led2_q, led2_d;
  logic           err_q, err_d;

  logic           is_sub;
  logic [W-1:0]   op_b;
  logic [SLICE_W-1:0] slice_a, slice_b;
  logic           slice_cin;
  logic [SLICE_W:0]   slice_sum;

  always_comb begin
    is_sub = (sign_q == OP_SUB);
    op_b   = is_sub ? ~b_q : b_q;

    // The one shared slice adder: low bytes with the op's carry-in, else high bytes with the registered low carry.
    if (state_q == ST_LOW) begin
      slice_a   = a_q[SLICE_W-1:0];
      slice_b   = op_b[SLICE_W-1:0];
      slice_cin = is_sub;
    end else begin
      slice_a   = a_q[W-1:SLICE_W];
      slice_b   = op_b[W-1:SLICE_W];
      slice_cin = carry_out_q;
    end
    slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE_W{1'b0}}, slice_cin};
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sign_d      = sign_q;
    carry_out_d = carry_out_q;
    result_d    = result_q;
    carry_d     = carry_q;
    led2_d      = led2_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d    = a;
          b_d    = b;
          sign_d = sign;
          err_d  = 1'b0;
          if (sign == OP_ADD || sign == OP_SUB) begin
            state_d = ST_LOW;
          end else begin
            state_d  = ST_DONE;
            err_d    = 1'b1;
            result_d = '0;
            carry_d  = 1'b0;
            led2_d   = 1'b0;
          end
        end
      end
      ST_LOW: begin
        result_d[SLICE_W-1:0] = slice_sum[SLICE_W-1:0];
        carry_out_d           = slice_sum[SLICE_W];
        state_d               = ST_HIGH;
      end
      ST_HIGH: begin
        result_d[W-1:SLICE_W] = slice_sum[SLICE_W-1:0];
        // Subtraction reports borrow, which is the inverse of the raw carry.
        carry_d = is_sub ? ~slice_sum[SLICE_W] : slice_sum[SLICE_W];
        led2_d  = is_sub ? ~slice_sum[SLICE_W] : slice_sum[SLICE_W];
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sign_q      <= '0;
      carry_out_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      led2_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sign_q      <= sign_d;
      carry_out_q <= carry_out_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      led2_q      <= led2_d;
      err_q       <= err_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign islow     = (state_q == ST_LOW);
  assign done      = (state_q == ST_DONE);
  assign sign_out  = sign_q;
  assign carry_out = carry_out_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign led2      = led2_q;
  assign err       = err_q;

endmodule
